// File: rtl/ram_param.sv
// ram_param: single-port word memory with registered read data, a
// self-zeroing sweep after reset or on request, and an out-of-range flag.
//
// Handshake: an access is taken at a rising edge when enable=1 and busy=0.
// There is no ready/stall back to the requester; while busy=1 requests are
// dropped. A read answers one cycle later with valid=1 for exactly one cycle.
// An out-of-range access answers one cycle later with erro=1 for exactly one
// cycle. valid and erro are mutually exclusive.
//
// The FSM state is directly observable on busy (busy=1 <=> state INIT).
module ram_param #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              enable,
  input  logic              rw,
  input  logic [ADDR_W-1:0] endereco,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              init,
  output logic [WIDTH-1:0]  data_out,
  output logic              valid,
  output logic              busy,
  output logic              erro
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_IDLE = 1'b1
  } state_e;

  // Last address touched by the sweep, and DEPTH widened by one bit so the
  // range test also works when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              erro_q, erro_d;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              in_range;

  assign in_range = ({1'b0, endereco} < DEPTH_EXT);

  // Next-state, memory write port and output register inputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    erro_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;

    case (state_q)
      S_INIT: begin
        // Sweep: zero one word per cycle; accesses and init are ignored.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_IDLE: begin
        if (init) begin
          // init wins over any access presented in the same cycle.
          state_d = S_INIT;
          cnt_d   = '0;
        end else if (enable) begin
          if (!in_range) begin
            dout_d = '0;
            erro_d = 1'b1;
          end else if (rw) begin
            mem_we    = 1'b1;
            mem_waddr = endereco;
            mem_wdata = data_in;
          end else begin
            dout_d  = mem_q[endereco];
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and output registers; clear forces the sweep to start over.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      erro_q  <= erro_d;
    end
  end

  // Storage array: no reset, contents are established by the sweep.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out = dout_q;
  assign valid    = valid_q;
  assign erro     = erro_q;
  assign busy     = (state_q == S_INIT);

endmodule

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 4: number of words (>=2).
REQ-003 Parameter ADDR_W, default 2: address width; 2**ADDR_W SHALL be >= DEPTH.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 clear  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  access request qualifier.
REQ-007 rw  input  1  1 = write, 0 = read.
REQ-008 endereco  input  ADDR_W  word address.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 init  input  1  request software zeroing of whole memory.
REQ-011 data_out  output  WIDTH  registered read data.
REQ-012 valid  output  1  data_out holds fresh read data this cycle.
REQ-013 busy  output  1  block is sweeping; accesses not accepted.
REQ-014 erro  output  1  previous-cycle access used an out-of-range address.

Function
REQ-015 Two-state FSM: INIT, IDLE; busy SHALL be 1 exactly while state is INIT.
REQ-016 INIT: sweep counter runs 0..DEPTH-1, writing zero to mem[counter] each cycle; after writing DEPTH-1, next state IDLE, counter returns to 0; sweep takes exactly DEPTH cycles.
REQ-017 IDLE with init=1: next state INIT at the following edge; the access presented that cycle SHALL be dropped (init has priority).
REQ-018 init=1 while in INIT SHALL be ignored; the sweep does not restart.
REQ-019 enable, rw, endereco, data_in SHALL be ignored in INIT; valid and erro stay 0.
REQ-020 IDLE write (enable=1, rw=1, endereco<DEPTH): mem[endereco] <= data_in at the edge; data_out unchanged; valid=0 next cycle.
REQ-021 IDLE read (enable=1, rw=0, endereco<DEPTH): data_out <= mem[endereco] at the edge; valid=1 for exactly the next cycle; read latency 1 cycle.
REQ-022 Read one cycle after a write to the same address SHALL return the newly written data.
REQ-023 Out-of-range access (enable=1, endereco>=DEPTH): no memory change; data_out <= 0; erro=1 for exactly the next cycle; valid=0.
REQ-024 enable=0 in IDLE: data_out holds its value; valid=0; erro=0.
REQ-025 valid and erro SHALL never be 1 in the same cycle.

Reset
REQ-026 While clear=0: state INIT, counter 0, data_out=0, valid=0, erro=0, busy=1, asynchronously, independent of clock.
REQ-027 Memory array is not reset directly; it SHALL be zeroed by the sweep that starts at the first rising edge after clear returns to 1.
REQ-028 clear asserted mid-sweep or mid-access SHALL abort it; after release the full DEPTH-cycle sweep restarts from address 0.

Verification
REQ-029 Defaults; release clear -> busy=1 for 4 cycles then 0; read addresses 0..3 -> data_out=0x00 each, valid=1 one cycle after each request.
REQ-030 Write 0xA5 @1, next cycle read @1 -> data_out=0xA5, valid=1 exactly one cycle later; read @0 -> 0x00.
REQ-031 DEPTH=3, ADDR_W=2; write 0xFF @3 -> erro=1 one cycle, valid=0, data_out=0x00; read @0..2 -> all unchanged.
REQ-032 Write 0x3C @2, then init=1 together with write 0x77 @0 -> 0x77 dropped, busy=1 for 4 cycles; afterwards read @2 -> 0x00, @0 -> 0x00.
REQ-033 clear pulsed low during sweep cycle 2 -> outputs 0 and busy=1 immediately; after release busy=1 for full 4 cycles; read @3 -> 0x00.
REQ-034 Requests (read @1, write 0x11 @1) during INIT -> valid=0, erro=0; after sweep read @1 -> 0x00.
